// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller and the VGA pixel generator:
// state codes, digit width and score saturation limit.
package game_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SCORE_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_B_RST  = 3'd1,
    ST_B_PLAY = 3'd2,
    ST_PLAY   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  // Score increment that sticks at the largest displayable digit.
  function automatic logic [DIGIT_W-1:0] sat_inc(input logic [DIGIT_W-1:0] v, input logic en);
    if (en && (v != SCORE_MAX)) begin
      return v + 4'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick generator: counts 0..TICK_DIV-1 while enabled and pulses
// tick on the wrapping cycle; clr or a low en forces the count back to zero.
module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  // Cycle counter with wrap, clear and hold-at-zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || !en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Match sequencer: idle -> blank -> countdown -> play -> finish, with per-player scores.
// Optional macro AUTO_RESTART_EN: FINISH returns to RST by itself after FINISH_SECS ticks.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 100_000_000,
  parameter int CNT_INIT    = 3,
  parameter int WIN_SCORE   = 7,
  parameter int FINISH_SECS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       point0,
  input  logic       point1,
  output logic [2:0] state,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] cnt0
);

  localparam logic [DIGIT_W-1:0] WIN_VAL  = DIGIT_W'(WIN_SCORE);
  localparam logic [DIGIT_W-1:0] CNT_LOAD = DIGIT_W'(CNT_INIT);

  state_t             r_state;
  logic [DIGIT_W-1:0] r_score0;
  logic [DIGIT_W-1:0] r_score1;
  logic [DIGIT_W-1:0] r_cnt0;

  logic               w_tick;
  logic               w_tick_en;
  logic               w_state_chg;
  logic               w_win;
  logic [DIGIT_W-1:0] w_score0_nxt;
  logic [DIGIT_W-1:0] w_score1_nxt;

`ifdef AUTO_RESTART_EN
  localparam logic [3:0] SECS_LAST = 4'(FINISH_SECS - 1);
  logic [3:0] r_secs;
`endif

  assign w_score0_nxt = sat_inc(r_score0, point0);
  assign w_score1_nxt = sat_inc(r_score1, point1);
  // Only a score that actually moved can end the match.
  assign w_win = ((w_score0_nxt != r_score0) && (w_score0_nxt == WIN_VAL)) ||
                 ((w_score1_nxt != r_score1) && (w_score1_nxt == WIN_VAL));

`ifdef AUTO_RESTART_EN
  assign w_tick_en = (r_state == ST_B_RST) || (r_state == ST_B_PLAY) || (r_state == ST_FINISH);
`else
  assign w_tick_en = (r_state == ST_B_RST) || (r_state == ST_B_PLAY);
`endif

  // Flags the edges on which the FSM leaves its current state, so each phase starts from a zero count.
  always_comb begin
    w_state_chg = 1'b0;
    case (r_state)
      ST_RST:    w_state_chg = start;
      ST_B_RST:  w_state_chg = w_tick;
      ST_B_PLAY: w_state_chg = w_tick && (r_cnt0 == 4'd1);
      ST_PLAY:   w_state_chg = w_win;
`ifdef AUTO_RESTART_EN
      ST_FINISH: w_state_chg = start || (w_tick && (r_secs == SECS_LAST));
`else
      ST_FINISH: w_state_chg = start;
`endif
      default:   w_state_chg = 1'b1;
    endcase
  end

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_state_chg),
    .en  (w_tick_en),
    .tick(w_tick)
  );

  // Match FSM with registered scores and countdown digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_RST;
      r_score0 <= 4'd0;
      r_score1 <= 4'd0;
      r_cnt0   <= 4'd0;
`ifdef AUTO_RESTART_EN
      r_secs   <= 4'd0;
`endif
    end else begin
      case (r_state)
        ST_RST: begin
          r_cnt0   <= 4'd0;
          r_score0 <= 4'd0;
          r_score1 <= 4'd0;
          if (start) begin
            r_state <= ST_B_RST;
          end else begin
            r_state <= ST_RST;
          end
        end
        ST_B_RST: begin
          if (w_tick) begin
            r_state <= ST_B_PLAY;
            r_cnt0  <= CNT_LOAD;
          end else begin
            r_state <= ST_B_RST;
          end
        end
        ST_B_PLAY: begin
          if (w_tick && (r_cnt0 == 4'd1)) begin
            r_state <= ST_PLAY;
            r_cnt0  <= 4'd0;
          end else if (w_tick) begin
            r_cnt0  <= r_cnt0 - 4'd1;
          end else begin
            r_state <= ST_B_PLAY;
          end
        end
        ST_PLAY: begin
          r_cnt0   <= 4'd0;
          r_score0 <= w_score0_nxt;
          r_score1 <= w_score1_nxt;
          if (w_win) begin
            r_state <= ST_FINISH;
          end else begin
            r_state <= ST_PLAY;
          end
        end
        ST_FINISH: begin
          r_cnt0 <= 4'd0;
`ifdef AUTO_RESTART_EN
          if (start || (w_tick && (r_secs == SECS_LAST))) begin
            r_state  <= ST_RST;
            r_score0 <= 4'd0;
            r_score1 <= 4'd0;
            r_secs   <= 4'd0;
          end else if (w_tick) begin
            r_secs   <= r_secs + 4'd1;
          end else begin
            r_state  <= ST_FINISH;
          end
`else
          if (start) begin
            r_state  <= ST_RST;
            r_score0 <= 4'd0;
            r_score1 <= 4'd0;
          end else begin
            r_state  <= ST_FINISH;
          end
`endif
        end
        default: begin
          r_state  <= ST_RST;
          r_score0 <= 4'd0;
          r_score1 <= 4'd0;
          r_cnt0   <= 4'd0;
        end
      endcase
    end
  end

  assign state  = r_state;
  assign score0 = r_score0;
  assign score1 = r_score1;
  assign cnt0   = r_cnt0;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with TICK_DIV=4, CNT_INIT=3, WIN_SCORE=2, FINISH_SECS=2.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       point0 = 1'b0;
  logic       point1 = 1'b0;
  logic [2:0] state;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] cnt0;
  logic [14:0] obs;

  int n_vec = 0;
  int n_err = 0;

  assign obs = {state, score0, score1, cnt0};

  game_flow_ctrl #(
    .TICK_DIV(4), .CNT_INIT(3), .WIN_SCORE(2), .FINISH_SECS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .point0(point0), .point1(point1),
    .state(state), .score0(score0), .score1(score1), .cnt0(cnt0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic p0, input logic p1);
    start = s; point0 = p0; point1 = p1;
    step();
    start = 1'b0; point0 = 1'b0; point1 = 1'b0;
  endtask

  task automatic go_play();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (16) step();
    n_vec++;
    if (obs !== {3'd3, 4'd0, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL go_play: got %h want %h", obs, {3'd3, 4'd0, 4'd0, 4'd0});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_vec++;
    if (obs !== 15'd0) begin
      n_err++; $display("FAIL reset_hold: got %h want 0", obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      n_vec++;
      if (obs !== 15'd0) begin
        n_err++; $display("FAIL idle cyc %0d: got %h want 0", i, obs);
      end
    end
  endtask

  task automatic test_countdown();
    logic [14:0] exp;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i < 4) exp = {3'd1, 4'd0, 4'd0, 4'd0};
      else       exp = {3'd2, 4'd0, 4'd0, 4'(3 - (i - 4) / 4)};
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL countdown cyc %0d: got %h want %h", i, obs, exp);
      end
      step();
    end
    n_vec++;
    if (obs !== {3'd3, 4'd0, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL play_entry: got %h want %h", obs, {3'd3, 4'd0, 4'd0, 4'd0});
    end
  endtask

  task automatic test_scoring();
    pulse(1'b0, 1'b1, 1'b0);
    n_vec++;
    if (obs !== {3'd3, 4'd1, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL score_p0: got %h want %h", obs, {3'd3, 4'd1, 4'd0, 4'd0});
    end
    pulse(1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs !== {3'd3, 4'd1, 4'd1, 4'd0}) begin
      n_err++; $display("FAIL score_p1: got %h want %h", obs, {3'd3, 4'd1, 4'd1, 4'd0});
    end
    pulse(1'b0, 1'b1, 1'b0);
    n_vec++;
    if (obs !== {3'd4, 4'd2, 4'd1, 4'd0}) begin
      n_err++; $display("FAIL win_p0: got %h want %h", obs, {3'd4, 4'd2, 4'd1, 4'd0});
    end
    pulse(1'b0, 1'b1, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs !== {3'd4, 4'd2, 4'd1, 4'd0}) begin
      n_err++; $display("FAIL finish_frozen: got %h want %h", obs, {3'd4, 4'd2, 4'd1, 4'd0});
    end
`ifndef AUTO_RESTART_EN
    repeat (20) step();
    n_vec++;
    if (obs !== {3'd4, 4'd2, 4'd1, 4'd0}) begin
      n_err++; $display("FAIL finish_hold: got %h want %h", obs, {3'd4, 4'd2, 4'd1, 4'd0});
    end
`endif
    pulse(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs !== 15'd0) begin
      n_err++; $display("FAIL finish_exit: got %h want 0", obs);
    end
  endtask

  task automatic test_tie();
    go_play();
    pulse(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs !== {3'd3, 4'd0, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL start_in_play: got %h want %h", obs, {3'd3, 4'd0, 4'd0, 4'd0});
    end
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    n_vec++;
    if (obs !== {3'd3, 4'd1, 4'd1, 4'd0}) begin
      n_err++; $display("FAIL tie_setup: got %h want %h", obs, {3'd3, 4'd1, 4'd1, 4'd0});
    end
    pulse(1'b0, 1'b1, 1'b1);
    n_vec++;
    if (obs !== {3'd4, 4'd2, 4'd2, 4'd0}) begin
      n_err++; $display("FAIL tie_win: got %h want %h", obs, {3'd4, 4'd2, 4'd2, 4'd0});
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs !== 15'd0) begin
      n_err++; $display("FAIL tie_restart: got %h want 0", obs);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] exp;
    pulse(1'b1, 1'b0, 1'b0);
    repeat (8) step();
    n_vec++;
    if (obs !== {3'd2, 4'd0, 4'd0, 4'd2}) begin
      n_err++; $display("FAIL pre_abort: got %h want %h", obs, {3'd2, 4'd0, 4'd0, 4'd2});
    end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== 15'd0) begin
      n_err++; $display("FAIL async_abort: got %h want 0", obs);
    end
    step();
    rst = 1'b0;
    // Restart, then try to disturb blank/countdown with start and point pulses.
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i < 4) exp = {3'd1, 4'd0, 4'd0, 4'd0};
      else       exp = {3'd2, 4'd0, 4'd0, 4'(3 - (i - 4) / 4)};
      n_vec++;
      if (obs !== exp) begin
        n_err++; $display("FAIL ignore cyc %0d: got %h want %h", i, obs, exp);
      end
      start  = (i == 1) || (i == 6) || (i == 13);
      point0 = (i == 2) || (i == 15);
      point1 = (i == 9);
      step();
      start = 1'b0; point0 = 1'b0; point1 = 1'b0;
    end
    n_vec++;
    if (obs !== {3'd3, 4'd0, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL ignore_play: got %h want %h", obs, {3'd3, 4'd0, 4'd0, 4'd0});
    end
  endtask

  task automatic test_auto_restart();
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
`ifdef AUTO_RESTART_EN
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (obs !== {3'd4, 4'd2, 4'd0, 4'd0}) begin
        n_err++; $display("FAIL auto cyc %0d: got %h want %h", i, obs, {3'd4, 4'd2, 4'd0, 4'd0});
      end
      step();
    end
    n_vec++;
    if (obs !== 15'd0) begin
      n_err++; $display("FAIL auto_return: got %h want 0", obs);
    end
`else
    repeat (12) step();
    n_vec++;
    if (obs !== {3'd4, 4'd2, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL no_auto: got %h want %h", obs, {3'd4, 4'd2, 4'd0, 4'd0});
    end
    pulse(1'b1, 1'b0, 1'b0);
    n_vec++;
    if (obs !== 15'd0) begin
      n_err++; $display("FAIL no_auto_exit: got %h want 0", obs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_scoring();
    test_tie();
    test_async_reset();
    test_auto_restart();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Game-flow controller that produces the `state`, `score0`, `score1` and `cnt0` buses consumed by the VGA pixel generator.
- Sequences the match: idle → blank → countdown → play → finish. Counts points per player and generates the 1 s countdown timing.
- Sits between the debounced/one-pulsed button and sensor inputs and the display path.

Parameters:
- TICK_DIV, 100_000_000, clk cycles per 1 s tick (100 MHz board clock)
- CNT_INIT, 3, first countdown value shown in B_PLAY (1..9)
- WIN_SCORE, 7, score that ends the match (1..9)
- FINISH_SECS, 5, ticks spent in FINISH before auto-return (used only with AUTO_RESTART_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse, start/restart request
- point0  in  1  one-cycle pulse, right player scored
- point1  in  1  one-cycle pulse, left player scored
- state  out  3  game state code: RST=0, B_RST=1, B_PLAY=2, PLAY=3, FINISH=4
- score0  out  4  right player score, 0..9
- score1  out  4  left player score, 0..9
- cnt0  out  4  countdown digit; 0 outside B_PLAY

Behaviour:
- All outputs are registered.
- Asynchronous reset: state=RST, score0=0, score1=0, cnt0=0, tick counter=0. Reset asserted mid-match aborts immediately to these values.
- Tick generator: counter runs 0..TICK_DIV-1 and pulses `tick` for one cycle when it wraps. The counter clears on every state change, so each phase lasts exactly N·TICK_DIV cycles from entry. The counter is held at 0 in RST and PLAY.
- FSM transitions:
  - RST: scores hold at 0. On `start` → B_RST. score0/score1 clear at this transition.
  - B_RST (blank screen): on the first tick → B_PLAY, with cnt0 loaded to CNT_INIT in the same edge.
  - B_PLAY: each tick decrements cnt0. On a tick with cnt0==1 → PLAY and cnt0=0.
  - PLAY:
    - `point0` increments score0; `point1` increments score1. Each score saturates at 9.
    - Simultaneous point0 and point1 in the same cycle: both increment.
    - If an incremented score equals WIN_SCORE, state becomes FINISH on the same edge the score updates.
    - If both scores reach WIN_SCORE together, the result is still FINISH; the display shows the tie.
  - FINISH: scores frozen. On `start` → RST with scores cleared.
- `start` is ignored in B_RST, B_PLAY and PLAY.
- point0/point1 are ignored outside PLAY, including the cycle of entry into PLAY only if the pulse precedes the state register update.
- Latency: a pulse sampled at edge N is reflected on the outputs after edge N; there are no extra pipeline stages.
- Illegal state codes 5..7 → RST on the next edge.

Optional Feature:
- Macro: AUTO_RESTART_EN.
- Defined: FINISH also counts ticks, and after FINISH_SECS ticks it moves to RST automatically. `start` in FINISH still exits immediately. The tick counter runs in FINISH, and a 4-bit seconds counter is added.
- Undefined: FINISH is left only by `start` or reset, and the tick counter is held at 0 in FINISH.

Decomposition:
- Shared package `game_pkg` holds:
  - state codes ST_RST, ST_B_RST, ST_B_PLAY, ST_PLAY, ST_FINISH (3-bit);
  - SCORE_MAX=9;
  - the score/digit width constant of 4.
  The pixel generator and this block share this package.
- One sub-module, `sec_tick_gen`:
  - inputs clk, rst, clr, en; output tick; parameter TICK_DIV.
  - Counter width is $clog2(TICK_DIV).

Test Plan (TICK_DIV=4, CNT_INIT=3, WIN_SCORE=2):
- Reset released, no input for 50 cycles → state=0, scores=0, cnt0=0 throughout.
- `start` pulse in RST →
  - state=1 for 4 cycles;
  - then state=2 with cnt0 = 3, 2, 1 for 4 cycles each;
  - then state=3 with cnt0=0.
- In PLAY, point0 then point1 pulses → score0=1, score1=1. A second point0 → score0=2 and state=4 on the same edge. Later point pulses leave scores unchanged.
- point0 and point1 in the same cycle at score 1-1 → both scores=2, state=4. Then `start` → state=0, scores=0.
- Reset asserted mid-B_PLAY (cnt0=2) → outputs 0/0/0/0 immediately without waiting for clk. `start` pulses during B_RST/B_PLAY are ignored (phase durations unchanged).
- AUTO_RESTART_EN, FINISH_SECS=2: reach FINISH, no start → state returns to 0 exactly 8 cycles after FINISH entry.
